inst_cache_ctrl: RTL

Direct-mapped, read-only instruction cache between the CPU fetch port (PC/INSTRUCTION) and the block-wide instruction memory. Hits return the 32-bit instruction in the same cycle. Misses stall the CPU via `busywait`, fetch a 128-bit block through a request/busywait handshake, install it, then complete as a hit. The block also keeps a miss counter for performance observation.

---
 rtl/inst_cache_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
// Hits return the addressed word combinationally; misses stall the CPU,
// fetch a 128-bit block over a request/busywait handshake, install it and
// then complete as a hit. A 16-bit counter tracks misses since reset.
module inst_cache_ctrl #(
  parameter int BLOCKS    = 8,
  parameter int ADDR_BITS = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          address,
  input  logic                 read,
  output logic [31:0]          readdata,
  output logic                 busywait,
  output logic                 mem_read,
  output logic [ADDR_BITS-5:0] mem_address,
  input  logic [127:0]         mem_readdata,
  input  logic                 mem_busywait,
  output logic [15:0]          miss_count
);

  localparam int INDEX_BITS = $clog2(BLOCKS);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [127:0]          data_q [BLOCKS];
  logic [TAG_BITS-1:0]   tag_q  [BLOCKS];
  logic [BLOCKS-1:0]     valid_q;
  logic [127:0]          fill_q;
  logic [15:0]           miss_count_q;

  // Address fields; byte-lane bits and the high PC bits play no part.
  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [1:0]            addr_offset;
  logic                  hit;
  logic                  unused_addr_bits;

  assign addr_tag         = address[ADDR_BITS-1 -: TAG_BITS];
  assign addr_index       = address[4 +: INDEX_BITS];
  assign addr_offset      = address[3:2];
  assign unused_addr_bits = ^{address[31:ADDR_BITS], address[1:0]};

  assign hit        = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign readdata   = data_q[addr_index][32*addr_offset +: 32];
  assign miss_count = miss_count_q;

  // Next-state decode and handshake outputs, all derived from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    unique case (state_q)
      IDLE: begin
        busywait = read && !hit;
        if (read && !hit) state_d = MEM_READ;
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_index};
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busywait = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, fill register and miss counter.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      fill_q       <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == MEM_READ) miss_count_q <= miss_count_q + 16'd1;
      if (state_q == MEM_READ && !mem_busywait)   fill_q <= mem_readdata;
      if (state_q == UPDATE)                      valid_q[addr_index] <= 1'b1;
    end
  end

  // Line install: data and tag written from the fill register in UPDATE.
  always_ff @(posedge CLK) begin
    // NOTE: data and tag arrays are deliberately not reset; the valid bits alone gate their use.
    if (!RESET && state_q == UPDATE) begin
      data_q[addr_index] <= fill_q;
      tag_q[addr_index]  <= addr_tag;
    end
  end

endmodule
